nrisc_coproc_muldiv: RTL and testbench
======================================

Name: nrisc_coproc_muldiv

Overview:
Iterative multiply/divide co-processor that sits directly downstream of the NRISC core's co-processor port. It consumes the operand pair and start strobe driven by the core, and returns a registered result that the core selects into its write-back path. Operations are unsigned shift-add multiply (low or high half) and restoring divide (quotient or remainder). It runs one iteration per clock, with a busy/done handshake so the core can stall until the result is valid.

Parameters:
TAM, 16, datapath width in bits; operands and result are TAM bits wide
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > TAM

Ports:
clk  input  1  main clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
CORE_CO_op  input  1  start strobe; sampled on a rising edge while state is IDLE or DONE
CORE_CO_func  input  2  operation: 00 MUL low, 01 MUL high, 10 DIV quotient, 11 DIV remainder
CORE_CO_A  input  TAM  operand A (multiplicand / dividend)
CORE_CO_B  input  TAM  operand B (multiplier / divisor)
CORE_CO_In  output  TAM  registered result; holds its value until the next completion
CORE_CO_busy  output  1  high while an operation is in progress (state RUN)
CORE_CO_done  output  1  one-cycle pulse; result is valid in that cycle
CORE_CO_dz  output  1  divide-by-zero flag; registered, updated at every completion

Behaviour:
- Reset (asynchronous, active-high, may occur mid-operation):
  - State goes to IDLE; counter and internal accumulators go to 0.
  - CORE_CO_In = 0, CORE_CO_busy = 0, CORE_CO_done = 0, CORE_CO_dz = 0.
  - Any operation in progress is abandoned and produces no done pulse.
- States:
  - IDLE -> RUN on an edge where CORE_CO_op = 1.
  - RUN -> DONE after the final iteration.
  - DONE -> RUN if CORE_CO_op = 1 on that edge (back-to-back start); otherwise DONE -> IDLE.
- Acceptance edge E0:
  - Latch A, B and func; clear counter; set busy = 1.
  - For DIV, clear the partial remainder.
- Stray strobes: CORE_CO_op while in RUN is ignored; the latched operands and func are unaffected.
- MUL:
  - 2*TAM-bit accumulator, shift-add, one multiplier bit per edge, LSB first.
  - Edges E1..E16 (TAM iterations) run the algorithm.
  - At E16 the state moves to DONE and CORE_CO_In is loaded with product[TAM-1:0] (func 00) or product[2*TAM-1:TAM] (func 01).
  - All arithmetic is unsigned. The product never overflows 2*TAM bits.
- DIV:
  - Restoring division, one quotient bit per edge, MSB first, over E1..E16.
  - At E16 the state moves to DONE and CORE_CO_In is loaded with the quotient (func 10) or the remainder (func 11).
- Divide by zero (B = 0 latched with func 1x):
  - No iterations are run; E1 moves to DONE.
  - Quotient = all ones; remainder = A.
  - CORE_CO_dz = 1.
- CORE_CO_dz = 0 at every other completion, including all MUL completions.
- Handshake timing:
  - busy is 1 exactly in RUN.
  - done = 1 exactly in DONE, one cycle only.
  - busy and done are never both 1.
- Latency: TAM edges from acceptance to done (1 edge for divide by zero).
- A back-to-back start accepted in DONE reloads the operands. CORE_CO_In keeps the just-finished result until the next completion.
- Operand and func inputs are only sampled at acceptance; changing them during RUN has no effect.

Test Plan:
- Reset then idle: rst pulse with no strobe -> CORE_CO_In=0x0000, busy=0, done=0, dz=0 held indefinitely.
- MUL: A=0x1234, B=0x0100, func=00, then func=01 -> low result 0x3400 and high result 0x0012; done pulses exactly 16 edges after acceptance; busy is high for the 16 cycles before done.
- MUL overflow: A=0xFFFF, B=0xFFFF -> func 00 gives 0x0001, func 01 gives 0xFFFE; dz=0.
- DIV: A=0x03E8, B=0x0007 -> func 10 gives 0x008E, func 11 gives 0x0006. A=5, B=9 -> quotient 0, remainder 5.
- DIV by zero: A=0x1234, B=0 -> quotient 0xFFFF (func 10), remainder 0x1234 (func 11); dz=1; done 1 edge after acceptance. A following MUL clears dz to 0.
- Back-to-back start and mid-op reset:
  - Strobe during DONE -> a new op starts with no IDLE cycle.
  - Strobe during RUN -> ignored; result matches the first operands.
  - rst asserted at iteration 8 -> all outputs 0 immediately (asynchronous); no done pulse; the next op completes correctly.

Source files
------------

// File: rtl/nrisc_coproc_muldiv_if.sv
// Co-processor port between the NRISC core and the mul/div unit.
// The core (master) drives the strobe and operands; the unit (slave) returns the result and handshake.
interface nrisc_coproc_muldiv_if #(
    parameter int TAM = 16
);
    logic           CORE_CO_op;
    logic [1:0]     CORE_CO_func;
    logic [TAM-1:0] CORE_CO_A;
    logic [TAM-1:0] CORE_CO_B;
    logic [TAM-1:0] CORE_CO_In;
    logic           CORE_CO_busy;
    logic           CORE_CO_done;
    logic           CORE_CO_dz;

    modport master (
        output CORE_CO_op, CORE_CO_func, CORE_CO_A, CORE_CO_B,
        input  CORE_CO_In, CORE_CO_busy, CORE_CO_done, CORE_CO_dz
    );

    modport slave (
        input  CORE_CO_op, CORE_CO_func, CORE_CO_A, CORE_CO_B,
        output CORE_CO_In, CORE_CO_busy, CORE_CO_done, CORE_CO_dz
    );
endinterface

// File: rtl/nrisc_coproc_muldiv.sv
// Iterative unsigned shift-add multiply / restoring divide, one bit per clock.
// Latency TAM edges after acceptance (1 for divide by zero); strobes while busy are dropped, core stalls on busy.
module nrisc_coproc_muldiv #(
    parameter int TAM   = 16,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    nrisc_coproc_muldiv_if.slave co
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         func_q;
    logic [TAM-1:0]     a_q;
    logic [TAM-1:0]     b_q;
    // Upper half: partial product / partial remainder. Lower half: multiplier / dividend-quotient.
    logic [2*TAM-1:0]   acc;
    logic [2*TAM-1:0]   acc_nxt;
    logic [TAM:0]       mul_sum;
    logic [TAM:0]       div_trial;
    logic [TAM-1:0]     result_nxt;
    logic               last_iter;
    logic               div_zero;

    assign last_iter = (cnt == CNT_W'(TAM - 1));
    assign div_zero  = func_q[1] && (b_q == '0);

    always_comb begin
        mul_sum   = {1'b0, acc[2*TAM-1:TAM]} + {1'b0, a_q & {TAM{acc[0]}}};
        div_trial = {acc[2*TAM-1:TAM], acc[TAM-1]} - {1'b0, b_q};
        acc_nxt   = acc;
        if (!func_q[1]) begin
            acc_nxt = {mul_sum, acc[TAM-1:1]};
        end else if (!div_trial[TAM]) begin
            acc_nxt = {div_trial[TAM-1:0], acc[TAM-2:0], 1'b1};
        end else begin
            acc_nxt = {acc[2*TAM-2:0], 1'b0};
        end
        // func[0] selects the upper half: MUL high word or DIV remainder.
        result_nxt = func_q[0] ? acc_nxt[2*TAM-1:TAM] : acc_nxt[TAM-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            func_q          <= '0;
            a_q             <= '0;
            b_q             <= '0;
            acc             <= '0;
            co.CORE_CO_In   <= '0;
            co.CORE_CO_busy <= 1'b0;
            co.CORE_CO_done <= 1'b0;
            co.CORE_CO_dz   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    co.CORE_CO_done <= 1'b0;
                    if (co.CORE_CO_op) begin
                        func_q          <= co.CORE_CO_func;
                        a_q             <= co.CORE_CO_A;
                        b_q             <= co.CORE_CO_B;
                        cnt             <= '0;
                        acc             <= co.CORE_CO_func[1] ? {{TAM{1'b0}}, co.CORE_CO_A}
                                                              : {{TAM{1'b0}}, co.CORE_CO_B};
                        co.CORE_CO_busy <= 1'b1;
                        state           <= RUN;
                    end else begin
                        state           <= IDLE;
                    end
                end
                RUN: begin
                    if (div_zero) begin
                        co.CORE_CO_In   <= func_q[0] ? a_q : {TAM{1'b1}};
                        co.CORE_CO_dz   <= 1'b1;
                        co.CORE_CO_busy <= 1'b0;
                        co.CORE_CO_done <= 1'b1;
                        state           <= DONE;
                    end else begin
                        acc <= acc_nxt;
                        cnt <= cnt + CNT_W'(1);
                        if (last_iter) begin
                            co.CORE_CO_In   <= result_nxt;
                            co.CORE_CO_dz   <= 1'b0;
                            co.CORE_CO_busy <= 1'b0;
                            co.CORE_CO_done <= 1'b1;
                            state           <= DONE;
                        end
                    end
                end
                default: begin
                    co.CORE_CO_busy <= 1'b0;
                    co.CORE_CO_done <= 1'b0;
                    state           <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nrisc_coproc_muldiv.sv
// Bench for nrisc_coproc_muldiv: directed vector table, multi-cycle corner sequences
// and randomized operations checked against an arithmetic reference model.
module tb_nrisc_coproc_muldiv;
    localparam int TAM = 16;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    nrisc_coproc_muldiv_if #(.TAM(TAM)) co ();

    nrisc_coproc_muldiv #(.TAM(TAM), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .co  (co)
    );

    typedef struct {
        string       name;
        logic [1:0]  f;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        dz;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference: {dz, result} from plain unsigned arithmetic.
    function automatic logic [16:0] model(input logic [1:0] f, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p = {16'd0, a} * {16'd0, b};
        case (f)
            2'd0:    return {1'b0, p[15:0]};
            2'd1:    return {1'b0, p[31:16]};
            2'd2:    return (b == 16'd0) ? {1'b1, 16'hFFFF} : {1'b0, a / b};
            default: return (b == 16'd0) ? {1'b1, a} : {1'b0, a % b};
        endcase
    endfunction

    // Issues one op, scrambles inputs during RUN (optionally with a stray strobe), waits for done.
    task automatic run_op(input logic [1:0] f, input logic [15:0] a, input logic [15:0] b,
                          input int stray_at, output logic [15:0] res, output logic dz,
                          output int lat, output logic hs_ok);
        hs_ok = 1'b1;
        lat   = -1;
        @(negedge clk);
        co.CORE_CO_op   = 1'b1;
        co.CORE_CO_func = f;
        co.CORE_CO_A    = a;
        co.CORE_CO_B    = b;
        @(posedge clk); #1;
        if (co.CORE_CO_busy !== 1'b1 || co.CORE_CO_done !== 1'b0) hs_ok = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            co.CORE_CO_op   = (n == stray_at);
            co.CORE_CO_func = 2'($urandom);
            co.CORE_CO_A    = 16'($urandom);
            co.CORE_CO_B    = 16'($urandom);
            @(posedge clk); #1;
            if (co.CORE_CO_busy === 1'b1 && co.CORE_CO_done === 1'b1) hs_ok = 1'b0;
            if (co.CORE_CO_done === 1'b1) begin
                lat = n;
                break;
            end
            if (co.CORE_CO_busy !== 1'b1) hs_ok = 1'b0;
        end
        co.CORE_CO_op = 1'b0;
        res = co.CORE_CO_In;
        dz  = co.CORE_CO_dz;
    endtask

    task automatic do_op(input string name, input logic [1:0] f, input logic [15:0] a,
                         input logic [15:0] b, input int stray_at, input logic [15:0] exp_res,
                         input logic exp_dz, input int exp_lat);
        logic [15:0] res;
        logic        dz;
        int          lat;
        logic        hs_ok;
        run_op(f, a, b, stray_at, res, dz, lat, hs_ok);
        check({name, "_lat"}, 32'(lat), 32'(exp_lat));
        check({name, "_res"}, {16'd0, res}, {16'd0, exp_res});
        check({name, "_dz"}, {31'd0, dz}, {31'd0, exp_dz});
        check({name, "_hs"}, {31'd0, hs_ok}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[11];
        logic [16:0] m;
        logic [1:0]  rf;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        seen_done;

        vt[0]  = '{"mul_lo",       2'd0, 16'h1234, 16'h0100, 16'h3400, 1'b0, 16};
        vt[1]  = '{"mul_hi",       2'd1, 16'h1234, 16'h0100, 16'h0012, 1'b0, 16};
        vt[2]  = '{"ovf_lo",       2'd0, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 16};
        vt[3]  = '{"ovf_hi",       2'd1, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 16};
        vt[4]  = '{"div_q",        2'd2, 16'h03E8, 16'h0007, 16'h008E, 1'b0, 16};
        vt[5]  = '{"div_r",        2'd3, 16'h03E8, 16'h0007, 16'h0006, 1'b0, 16};
        vt[6]  = '{"div_small_q",  2'd2, 16'h0005, 16'h0009, 16'h0000, 1'b0, 16};
        vt[7]  = '{"div_small_r",  2'd3, 16'h0005, 16'h0009, 16'h0005, 1'b0, 16};
        vt[8]  = '{"dz_q",         2'd2, 16'h1234, 16'h0000, 16'hFFFF, 1'b1, 1};
        vt[9]  = '{"dz_r",         2'd3, 16'h1234, 16'h0000, 16'h1234, 1'b1, 1};
        vt[10] = '{"mul_after_dz", 2'd0, 16'h0003, 16'h0005, 16'h000F, 1'b0, 16};

        co.CORE_CO_op   = 1'b0;
        co.CORE_CO_func = 2'd0;
        co.CORE_CO_A    = 16'd0;
        co.CORE_CO_B    = 16'd0;
        rst = 1'b1;
        #12;
        check("reset_outputs", {13'd0, co.CORE_CO_In, co.CORE_CO_busy, co.CORE_CO_done, co.CORE_CO_dz}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("idle_hold", {13'd0, co.CORE_CO_In, co.CORE_CO_busy, co.CORE_CO_done, co.CORE_CO_dz}, 32'd0);
        end

        // Consecutive entries start back-to-back from DONE.
        for (int i = 0; i < 11; i++) begin
            do_op(vt[i].name, vt[i].f, vt[i].a, vt[i].b, 0, vt[i].res, vt[i].dz, vt[i].lat);
        end

        @(posedge clk); #1;
        check("done_one_cycle", {31'd0, co.CORE_CO_done}, 32'd0);
        check("result_held", {16'd0, co.CORE_CO_In}, 32'h0000_000F);
        repeat (3) @(posedge clk);

        do_op("stray_mul", 2'd0, 16'h0101, 16'h0033, 5, 16'h3333, 1'b0, 16);
        do_op("stray_div", 2'd3, 16'hBEEF, 16'h0100, 9, 16'h00EF, 1'b0, 16);

        // Reset in the middle of an operation, with nonzero result and dz beforehand.
        do_op("pre_rst_dz", 2'd2, 16'h4321, 16'h0000, 0, 16'hFFFF, 1'b1, 1);
        @(negedge clk);
        co.CORE_CO_op   = 1'b1;
        co.CORE_CO_func = 2'd0;
        co.CORE_CO_A    = 16'h0007;
        co.CORE_CO_B    = 16'h0009;
        @(posedge clk); #1;
        co.CORE_CO_op = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midop_rst_outputs", {13'd0, co.CORE_CO_In, co.CORE_CO_busy, co.CORE_CO_done, co.CORE_CO_dz}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (co.CORE_CO_done === 1'b1 || co.CORE_CO_busy === 1'b1) seen_done = 1'b1;
        end
        check("midop_rst_no_done", {31'd0, seen_done}, 32'd0);
        do_op("after_rst", 2'd0, 16'h0007, 16'h0009, 0, 16'h003F, 1'b0, 16);

        for (int i = 0; i < 200; i++) begin
            rf = 2'($urandom);
            ra = 16'($urandom);
            rb = ($urandom_range(7, 0) == 0) ? 16'd0 : 16'($urandom);
            m  = model(rf, ra, rb);
            do_op("rand", rf, ra, rb, (i % 4 == 0) ? int'($urandom_range(14, 1)) : 0,
                  m[15:0], m[16], (rf[1] && rb == 16'd0) ? 1 : 16);
            if ($urandom_range(3, 0) == 0) repeat (2) @(posedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
